// File: rtl/stage_if_pkg.sv
// Shared CPU constants used by the instruction-fetch stage.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package stage_if_pkg;

    // Address of the first instruction fetched after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

    // Byte distance between sequential instructions.
    localparam logic [31:0] PC_INCR = 32'd4;

    // Sequential successor of a PC; the 32-bit add wraps naturally past 32'hfffffffc.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/stage_if_pipe.sv
// Generic pipeline-stage valid bit with the valid/allowin/validout handshake.
// Latency: valid updates on the rising edge after load_i.
// Backpressure: allowin_o drops while the stage is full and downstream cannot accept.
module stage_if_pipe (
    input  logic clk,
    input  logic rst,
    input  logic validin_i,
    input  logic readygo_i,
    input  logic allowout_i,
    input  logic load_i,
    output logic valid_o,
    output logic allowin_o,
    output logic validout_o
);

    logic valid_q;
    logic valid_d;

    assign allowin_o  = ~valid_q | (readygo_i & allowout_i);
    assign validout_o = valid_q & readygo_i;
    assign valid_o    = valid_q;

    // Next valid: take the upstream valid when loading, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        if (load_i) begin
            valid_d = validin_i;
        end
    end

    // Valid register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: drives the SRAM with nextpc and presents the fetched word to ID.
// Latency: one cycle from fetch request to validout; no bubble on handoff-plus-fetch.
// Backpressure: on allowout=0 the fetch stalls and the SRAM word is parked in inst_buf.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        allowout,
    output logic        validout,
    output logic [31:0] output_pc,
    output logic [31:0] output_inst,
    input  logic        input_br_taken,
    input  logic [31:0] input_br_target,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inst_buf_q;
    logic [31:0] inst_buf_d;
    logic        buf_valid_q;
    logic        buf_valid_d;

    logic [31:0] nextpc;
    logic        valid;
    logic        pipe_allowin;
    logic        pipe_validout;
    logic        if_allowin;

    // A redirect overrides the sequential successor.
    assign nextpc = input_br_taken ? input_br_target : seq_pc(pc_q);

    // The handshake core never stalls on its own (readygo=1); the redirect
    // cancel is folded in here: it removes the downstream dependency and
    // forces a fetch so the target is requested in the redirect cycle.
    stage_if_pipe u_pipe (
        .clk        (clk),
        .rst        (rst),
        .validin_i  (1'b1),
        .readygo_i  (1'b1),
        .allowout_i (allowout & ~input_br_taken),
        .load_i     (inst_sram_en),
        .valid_o    (valid),
        .allowin_o  (pipe_allowin),
        .validout_o (pipe_validout)
    );

    assign if_allowin = pipe_allowin | input_br_taken;

    assign inst_sram_en    = if_allowin & ~rst;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    // The IF slot is cancelled by a redirect; during reset the slot is
    // already being discarded, so nothing is offered to ID either.
    assign validout    = pipe_validout & ~input_br_taken & ~rst;
    assign output_pc   = pc_q;
    assign output_inst = buf_valid_q ? inst_buf_q : inst_sram_rdata;

    // Next PC and hold buffer: advance on fetch, park the SRAM word on a stall,
    // drop the parked word once it is handed off or cancelled.
    always_comb begin
        pc_d        = pc_q;
        inst_buf_d  = inst_buf_q;
        buf_valid_d = buf_valid_q;
        if (inst_sram_en) begin
            pc_d = nextpc;
        end
        if ((validout & allowout) | input_br_taken) begin
            buf_valid_d = 1'b0;
        end else if (valid & ~allowout & ~buf_valid_q) begin
            inst_buf_d  = inst_sram_rdata;
            buf_valid_d = 1'b1;
        end
    end

    // State registers; reset parks pc one slot before RESET_PC so the first
    // fetch after release requests RESET_PC through the normal increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC - PC_INCR;
            inst_buf_q  <= 32'h0;
            buf_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            inst_buf_q  <= inst_buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Directed self-checking bench for stage_if with a one-cycle-latency SRAM model.
// Latency: inputs driven after the falling edge, outputs sampled 1ns later.
// Backpressure: allowout driven directly by the stimulus sequence.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        allowout;
    logic        validout;
    logic [31:0] output_pc;
    logic [31:0] output_inst;
    logic        input_br_taken;
    logic [31:0] input_br_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'h0;
    logic [31:0] garbage_cnt = 32'h0;

    int n_chk  = 0;
    int n_fail = 0;

    stage_if dut (
        .clk             (clk),
        .rst             (rst),
        .allowout        (allowout),
        .validout        (validout),
        .output_pc       (output_pc),
        .output_inst     (output_inst),
        .input_br_taken  (input_br_taken),
        .input_br_target (input_br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    // Instruction word stored at a given address in the model SRAM.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579bdf;
    endfunction

    // SRAM model: real data one cycle after an enabled read, garbage otherwise.
    always @(posedge clk) begin
        if (inst_sram_en) begin
            inst_sram_rdata <= mem_word(inst_sram_addr);
        end else begin
            inst_sram_rdata <= 32'hbad00000 | garbage_cnt;
        end
        garbage_cnt <= garbage_cnt + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Wait for the next falling edge, apply inputs, then let outputs settle.
    task automatic drive(input logic r, input logic ao, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        rst             = r;
        allowout        = ao;
        input_br_taken  = br;
        input_br_target = tgt;
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        allowout        = 1'b1;
        input_br_taken  = 1'b0;
        input_br_target = 32'h0;
        #1;
        check("rst_validout", {31'b0, validout}, 32'd0);
        check("rst_en", {31'b0, inst_sram_en}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("rst_validout2", {31'b0, validout}, 32'd0);
        check("rst_en2", {31'b0, inst_sram_en}, 32'd0);

        // Reset release and sequential streaming.
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("c0_en", {31'b0, inst_sram_en}, 32'd1);
        check("c0_addr", inst_sram_addr, 32'h1c000000);
        check("c0_validout", {31'b0, validout}, 32'd0);
        check("we_const", {28'b0, inst_sram_we}, 32'd0);
        check("wdata_const", inst_sram_wdata, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("c1_validout", {31'b0, validout}, 32'd1);
        check("c1_pc", output_pc, 32'h1c000000);
        check("c1_inst", output_inst, mem_word(32'h1c000000));
        check("c1_addr", inst_sram_addr, 32'h1c000004);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("c2_pc", output_pc, 32'h1c000004);
        check("c2_addr", inst_sram_addr, 32'h1c000008);

        // Five-cycle hold on 1c000008 while the SRAM returns garbage.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            check("hold_validout", {31'b0, validout}, 32'd1);
            check("hold_pc", output_pc, 32'h1c000008);
            check("hold_inst", output_inst, mem_word(32'h1c000008));
            check("hold_en", {31'b0, inst_sram_en}, 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("resume_pc", output_pc, 32'h1c000008);
        check("resume_inst", output_inst, mem_word(32'h1c000008));
        check("resume_addr", inst_sram_addr, 32'h1c00000c);
        check("resume_en", {31'b0, inst_sram_en}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("next_pc", output_pc, 32'h1c00000c);
        check("next_inst", output_inst, mem_word(32'h1c00000c));

        // Three-cycle hold on 1c000010, then a redirect cancels it.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            check("hold2_pc", output_pc, 32'h1c000010);
            check("hold2_inst", output_inst, mem_word(32'h1c000010));
        end
        drive(1'b0, 1'b0, 1'b1, 32'h1c000100);
        check("br_validout", {31'b0, validout}, 32'd0);
        check("br_addr", inst_sram_addr, 32'h1c000100);
        check("br_en", {31'b0, inst_sram_en}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("tgt_validout", {31'b0, validout}, 32'd1);
        check("tgt_pc", output_pc, 32'h1c000100);
        check("tgt_inst", output_inst, mem_word(32'h1c000100));

        // Back-to-back redirects: the later target wins.
        drive(1'b0, 1'b1, 1'b1, 32'h1c000200);
        check("bb1_validout", {31'b0, validout}, 32'd0);
        check("bb1_addr", inst_sram_addr, 32'h1c000200);
        drive(1'b0, 1'b1, 1'b1, 32'h1c000300);
        check("bb2_validout", {31'b0, validout}, 32'd0);
        check("bb2_addr", inst_sram_addr, 32'h1c000300);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("bb_validout", {31'b0, validout}, 32'd1);
        check("bb_pc", output_pc, 32'h1c000300);
        check("bb_inst", output_inst, mem_word(32'h1c000300));
        check("bb_addr", inst_sram_addr, 32'h1c000304);

        // Redirect to the top of the address space wraps to zero.
        drive(1'b0, 1'b1, 1'b1, 32'hfffffffc);
        check("wrap_br_addr", inst_sram_addr, 32'hfffffffc);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("wrap_pc", output_pc, 32'hfffffffc);
        check("wrap_addr", inst_sram_addr, 32'h00000000);

        // Hold on address 0 until the buffer is filled, then pulse reset.
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("zero_pc", output_pc, 32'h00000000);
        check("zero_en", {31'b0, inst_sram_en}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("zero_buf_inst", output_inst, mem_word(32'h00000000));
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("mrst_validout", {31'b0, validout}, 32'd0);
        check("mrst_en", {31'b0, inst_sram_en}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("post_validout", {31'b0, validout}, 32'd0);
        check("post_addr", inst_sram_addr, 32'h1c000000);
        check("post_en", {31'b0, inst_sram_en}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("post_pc", output_pc, 32'h1c000000);
        check("post_inst", output_inst, mem_word(32'h1c000000));
        check("post_validout2", {31'b0, validout}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
